// File: rtl/pixel_buf_arbiter.sv
// pixel_buf_arbiter: owns the single port of the 28x28 1-bit image buffer.
// The port is granted every cycle in fixed priority: display read, then the
// clear sweep, then the write path, then the classifier stream.
// Optional build macro STREAM_LOCK_EN: holds off writes while streaming so
// the classifier sees a consistent snapshot of the image.
module pixel_buf_arbiter #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              disp_rd_en,
   input  logic [4:0]        disp_rd_x,
   input  logic [4:0]        disp_rd_y,
   output logic              disp_rd_data,
   input  logic              wr_req,
   input  logic [4:0]        wr_x,
   input  logic [4:0]        wr_y,
   input  logic              wr_data,
   output logic              wr_ack,
   input  logic              clr_req,
   input  logic              cls_start,
   output logic              cls_valid,
   output logic              cls_data,
   output logic              cls_last,
   input  logic              cls_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_wdata,
   input  logic              mem_rdata
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, STREAM} state_t;

   state_t            state, state_nxt;
   logic              done_nxt;
   logic [ADDR_W-1:0] clr_idx, str_idx;
   logic [ADDR_W-1:0] disp_addr, wr_addr;
   logic              disp_in, wr_in, wr_allow;
   logic              clr_go, str_issue, str_accept;

   // Row-major addresses, widened to ADDR_W before the multiply.
   assign disp_addr = ADDR_W'(disp_rd_y) * W_A + ADDR_W'(disp_rd_x);
   assign wr_addr   = ADDR_W'(wr_y) * W_A + ADDR_W'(wr_x);
   assign disp_in   = (int'(disp_rd_x) < IMG_W) && (int'(disp_rd_y) < IMG_H);
   assign wr_in     = (int'(wr_x) < IMG_W) && (int'(wr_y) < IMG_H);

`ifdef STREAM_LOCK_EN
   assign wr_allow = (state != STREAM);
`else
   assign wr_allow = 1'b1;
`endif

   assign busy       = (state != IDLE);
   assign str_accept = cls_valid && cls_ready;

   // Per-cycle port grant in strict priority. The stream stops issuing once
   // the last pixel is in the output register (cls_last set).
   always_comb begin
      disp_rd_data = 1'b0;
      mem_addr     = disp_addr;
      mem_we       = 1'b0;
      mem_wdata    = 1'b0;
      wr_ack       = 1'b0;
      clr_go       = 1'b0;
      str_issue    = 1'b0;
      if (disp_rd_en) begin
         disp_rd_data = disp_in & mem_rdata;
      end else if (state == CLEAR) begin
         mem_addr = clr_idx;
         mem_we   = 1'b1;
         clr_go   = 1'b1;
      end else if (wr_req && wr_allow) begin
         wr_ack    = 1'b1;
         mem_addr  = wr_addr;
         mem_we    = wr_in;
         mem_wdata = wr_data;
      end else if (state == STREAM && !cls_last && (!cls_valid || cls_ready)) begin
         mem_addr  = str_idx;
         str_issue = 1'b1;
      end
   end

   // State register plus the registered completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state: clear beats start; requests outside IDLE are ignored.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req)        state_nxt = CLEAR;
            else if (cls_start) state_nxt = STREAM;
         end
         CLEAR: begin
            if (clr_go && clr_idx == LAST_A) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         STREAM: begin
            if (str_accept && cls_last) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sweep/stream counters; both rewind while idle so each run starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_idx <= '0;
         str_idx <= '0;
      end else if (state == IDLE) begin
         clr_idx <= '0;
         str_idx <= '0;
      end else begin
         if (clr_go)    clr_idx <= clr_idx + ADDR_W'(1);
         if (str_issue) str_idx <= str_idx + ADDR_W'(1);
      end
   end

   // Stream output register: loads on issue, holds while stalled, drops on
   // an accept with nothing new behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_valid <= 1'b0;
         cls_data  <= 1'b0;
         cls_last  <= 1'b0;
      end else if (str_issue) begin
         cls_valid <= 1'b1;
         cls_data  <= mem_rdata;
         cls_last  <= (str_idx == LAST_A);
      end else if (str_accept) begin
         cls_valid <= 1'b0;
         cls_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pixel_buf_arbiter.sv
// Bench for pixel_buf_arbiter: bench-owned buffer RAM, an image-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_pixel_buf_arbiter;
   localparam int W = 28, H = 28, N = W * H;
`ifdef STREAM_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic clk = 0, rst_n = 0;
   logic disp_rd_en = 0, wr_req = 0, wr_data = 0, clr_req = 0, cls_start = 0, cls_ready = 0;
   logic [4:0] disp_rd_x = 0, disp_rd_y = 0, wr_x = 0, wr_y = 0;
   logic disp_rd_data, wr_ack, cls_valid, cls_data, cls_last, busy, done, mem_we, mem_wdata, mem_rdata;
   logic [9:0] mem_addr;

   pixel_buf_arbiter #(.IMG_W(W), .IMG_H(H), .ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_rd_en(disp_rd_en), .disp_rd_x(disp_rd_x), .disp_rd_y(disp_rd_y), .disp_rd_data(disp_rd_data),
      .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
      .clr_req(clr_req), .cls_start(cls_start),
      .cls_valid(cls_valid), .cls_data(cls_data), .cls_last(cls_last), .cls_ready(cls_ready),
      .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   // Buffer RAM: asynchronous read, synchronous write.
   bit ram [0:1023];
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

   int checks = 0, failures = 0;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Image-level model: expected picture, what the job is, how far along it
   // is, and what the stream output should be showing.
   bit golden [0:N-1];
   int m_mode = 0;          // 0 none, 1 clearing, 2 streaming
   int m_ci = 0, m_next = 0;
   bit m_vld = 0, m_dat = 0, m_last = 0, m_done = 0;

   always @(negedge clk) begin
      int da, wa;
      bit din, win, free, e_ack, e_we, iss, nd;
      if (!rst_n) begin
         m_mode = 0; m_vld = 0; m_last = 0; m_done = 0;
         chk("rst_cls_valid", cls_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         if (!wr_req && !disp_rd_en) begin
            chk("rst_mem_we", mem_we, 0);
            chk("rst_wr_ack", wr_ack, 0);
         end
      end else begin
         din   = (disp_rd_x < W) && (disp_rd_y < H);
         win   = (wr_x < W) && (wr_y < H);
         da    = disp_rd_y * W + disp_rd_x;
         wa    = wr_y * W + wr_x;
         free  = !disp_rd_en;
         e_ack = free && m_mode != 1 && wr_req && !(LOCK && m_mode == 2);
         e_we  = free && (m_mode == 1 || (e_ack && win));
         iss   = free && m_mode == 2 && !e_ack && m_next < N && (!m_vld || cls_ready);
         chk("disp_rd_data", disp_rd_data, (disp_rd_en && din) ? golden[da] : 0);
         chk("wr_ack", wr_ack, e_ack);
         chk("mem_we", mem_we, e_we);
         chk("busy", busy, m_mode != 0);
         chk("done", done, m_done);
         chk("cls_valid", cls_valid, m_vld);
         if (m_vld) begin
            chk("cls_data", cls_data, m_dat);
            chk("cls_last", cls_last, m_last);
         end
         if (disp_rd_en && din) chk("disp_addr", mem_addr, da);
         if (e_we) begin
            chk("wr_addr", mem_addr, m_mode == 1 ? m_ci : wa);
            chk("wr_wdata", mem_wdata, m_mode == 1 ? 0 : wr_data);
         end
         if (iss) chk("str_addr", mem_addr, m_next);
         // advance to what the coming edge must produce
         nd = 0;
         if (e_ack && win) golden[wa] = wr_data;
         case (m_mode)
            0: if (clr_req) begin m_mode = 1; m_ci = 0; end
               else if (cls_start) begin m_mode = 2; m_next = 0; end
            1: if (free) begin
                  golden[m_ci] = 0;
                  m_ci++;
                  if (m_ci == N) begin m_mode = 0; nd = 1; end
               end
            default: begin
               if (m_vld && cls_ready && m_last) begin
                  m_mode = 0; m_vld = 0; m_last = 0; nd = 1;
               end else if (iss) begin
                  m_dat = golden[m_next]; m_last = (m_next == N - 1); m_vld = 1; m_next++;
               end else if (m_vld && cls_ready) begin
                  m_vld = 0;
               end
            end
         endcase
         m_done = nd;
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   // Waits for the done pulse; a missed bound is a failed comparison.
   task automatic wait_done(input string nm, input int lim);
      int n;
      n = 0;
      while (!done && n < lim) begin @(negedge clk); n++; end
      chk({nm, "_done_timeout"}, done, 1);
      cyc();
   endtask

   bit got [$];
   int first, a_addr, a_we, k, donek, vseen, lastcnt, lastpos, lastc, donec, bad, n, acc;
   bit busyat, ack;

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 1'($urandom);
      for (int i = 0; i < N; i++) golden[i] = ram[i];
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      cyc();

      // Write held behind three display cycles, then an out-of-range write.
      disp_rd_en = 1; disp_rd_x = 5; disp_rd_y = 6;
      wr_req = 1; wr_x = 27; wr_y = 27; wr_data = 1;
      first = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (wr_ack && first == 0) begin first = c; a_addr = mem_addr; a_we = mem_we; end
         @(posedge clk); #1;
         if (c == 3) disp_rd_en = 0;
         if (first != 0) break;
      end
      chk("wr_first_ack_cycle", first, 4);
      chk("wr_addr_783", a_addr, 783);
      chk("wr_we_783", a_we, 1);
      wr_x = 28; wr_y = 0;
      @(negedge clk);
      chk("wr_oor_ack", wr_ack, 1);
      chk("wr_oor_we", mem_we, 0);
      cyc();
      wr_req = 0;
      cyc();

      // Clear while the display holds the port for 100 cycles.
      disp_rd_en = 1; disp_rd_x = 5'($urandom_range(0, 31)); disp_rd_y = 5'($urandom_range(0, 31));
      clr_req = 1;
      cyc();
      clr_req = 0;
      k = 0; donek = 0;
      while (k < 2000) begin
         @(posedge clk); k++; #1;
         if (k == 100) disp_rd_en = 0;
         else begin disp_rd_x = 5'($urandom_range(0, 31)); disp_rd_y = 5'($urandom_range(0, 31)); end
         if (done) begin donek = k; break; end
      end
      chk("clear_done_cycle", donek, 884);
      bad = 0;
      for (int i = 0; i < N; i++) if (ram[i]) bad++;
      chk("clear_nonzero_pixels", bad, 0);
      cyc();

      // Clear and start together: clear wins; a start during clear is dropped.
      clr_req = 1; cls_start = 1; cls_ready = 1;
      cyc();
      clr_req = 0; cls_start = 0;
      chk("clr_start_busy", busy, 1);
      repeat (50) cyc();
      cls_start = 1;
      cyc();
      cls_start = 0;
      vseen = 0; n = 0;
      while (!done && n < 2000) begin @(negedge clk); if (cls_valid) vseen++; n++; end
      chk("clr_start_done", done, 1);
      chk("clr_start_no_stream", vseen, 0);
      repeat (3) cyc();
      chk("clr_start_idle_after", busy, 0);

      // Checkerboard stream with a toggling ready and display interference.
      for (int i = 0; i < N; i++) begin
         ram[i] = 1'(((i % W) + (i / W)) & 1);
         golden[i] = ram[i];
      end
      cls_start = 1;
      cyc();
      cls_start = 0;
      got.delete(); lastcnt = 0; lastpos = -1; lastc = 0; donec = 0;
      for (int c = 0; c < 6000; c++) begin
         cls_ready = c[0];
         disp_rd_en = ($urandom_range(0, 3) == 0);
         disp_rd_x = 5'($urandom_range(0, 31)); disp_rd_y = 5'($urandom_range(0, 31));
         @(negedge clk);
         if (done) begin donec = c; break; end
         if (cls_valid && cls_ready) begin
            got.push_back(cls_data);
            if (cls_last) begin lastcnt++; lastpos = got.size() - 1; lastc = c; end
         end
         @(posedge clk); #1;
      end
      disp_rd_en = 0;
      cyc();
      chk("cb_count", got.size(), N);
      bad = 0;
      foreach (got[i]) if (got[i] != (((i % W) + (i / W)) & 1)) bad++;
      chk("cb_pattern_errors", bad, 0);
      chk("cb_last_count", lastcnt, 1);
      chk("cb_last_pos", lastpos, 783);
      chk("cb_done_after_last", donec - lastc, 1);

      // Reset in the middle of a stream, then a fresh stream from index 0.
      cls_ready = 1;
      cls_start = 1;
      cyc();
      cls_start = 0;
      acc = 0; n = 0;
      while (acc < 300 && n < 2000) begin
         @(negedge clk); if (cls_valid && cls_ready) acc++; n++;
      end
      chk("midstream_reached", acc, 300);
      @(posedge clk); #1 rst_n = 0;
      #1;
      chk("midrst_cls_valid", cls_valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      repeat (2) cyc();
      rst_n = 1;
      cyc();
      chk("after_rst_done", done, 0);
      cls_start = 1;
      cyc();
      cls_start = 0;
      got.delete(); n = 0;
      while (got.size() < 2 && n < 100) begin
         @(negedge clk); if (cls_valid && cls_ready) got.push_back(cls_data); n++;
      end
      chk("restart_count", got.size(), 2);
      chk("restart_px0", got.size() > 0 ? int'(got[0]) : -1, 0);
      chk("restart_px1", got.size() > 1 ? int'(got[1]) : -1, 1);
      wait_done("restart", 3000);

      // Write arriving mid-stream.
      cls_start = 1;
      cyc();
      cls_start = 0;
      repeat (10) cyc();
      wr_req = 1; wr_x = 3; wr_y = 3; wr_data = 1;
      n = 0; busyat = 1;
      while (n < 3000) begin
         @(negedge clk);
         if (wr_ack) begin busyat = busy; break; end
         n++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1 wr_req = 0;
      chk("stream_wr_ack_ok", LOCK ? int'(busyat == 0 && n > 0) : int'(n == 0), 1);
      if (busy) wait_done("lockstream", 3000);
      cyc();

      // Random traffic against the model.
      ack = 0;
      for (int c = 0; c < 4000; c++) begin
         disp_rd_en = ($urandom_range(0, 9) < 3);
         disp_rd_x = 5'($urandom_range(0, 31)); disp_rd_y = 5'($urandom_range(0, 31));
         if (!wr_req || ack) begin
            wr_req = ($urandom_range(0, 9) < 4);
            wr_x = 5'($urandom_range(0, 29)); wr_y = 5'($urandom_range(0, 29));
            wr_data = 1'($urandom);
         end
         clr_req = ($urandom_range(0, 399) == 0);
         cls_start = ($urandom_range(0, 49) == 0);
         cls_ready = ($urandom_range(0, 9) < 6);
         @(negedge clk); ack = wr_ack;
         @(posedge clk); #1;
      end
      disp_rd_en = 0; wr_req = 0; clr_req = 0; cls_start = 0; cls_ready = 1;
      n = 0;
      while (busy && n < 3000) begin cyc(); n++; end
      chk("final_idle", busy, 0);
      repeat (2) cyc();
      bad = 0;
      for (int i = 0; i < N; i++) if (ram[i] != golden[i]) bad++;
      chk("final_image_errors", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
